// File: rtl/tvs_pkg.sv
// Shared definitions for the TVS statistics monitor: write-select codes,
// control state encoding and default widths.
package tvs_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_CH_W   = 2;

    typedef enum logic [1:0] {
        SEL_AVG = 2'd0,
        SEL_MIN = 2'd1,
        SEL_MAX = 2'd2
    } sel_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCUM  = 3'd1,
        WR_AVG = 3'd2,
        WR_MIN = 3'd3,
        WR_MAX = 3'd4
    } state_e;

endpackage

// File: rtl/tvs_edge_capture.sv
// Two-stage valid synchroniser with rising-edge detect; the sample value and
// channel are registered alongside the first stage so they line up with the event.
module tvs_edge_capture
    import tvs_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CH_W   = DEF_CH_W
) (
    input  logic              clk,
    input  logic              resetn_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] value_i,
    input  logic [CH_W-1:0]   channel_i,
    output logic              event_o,
    output logic [DATA_W-1:0] value_o,
    output logic [CH_W-1:0]   channel_o
);

    logic              d1_q, d1_d;
    logic              d2_q, d2_d;
    logic [DATA_W-1:0] value_q, value_d;
    logic [CH_W-1:0]   channel_q, channel_d;

    always_comb begin
        d1_d      = valid_i;
        d2_d      = d1_q;
        value_d   = value_i;
        channel_d = channel_i;
    end

    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            d1_q      <= 1'b0;
            d2_q      <= 1'b0;
            value_q   <= '0;
            channel_q <= '0;
        end else begin
            d1_q      <= d1_d;
            d2_q      <= d2_d;
            value_q   <= value_d;
            channel_q <= channel_d;
        end
    end

    // One event per rising edge, regardless of how long valid stays high.
    assign event_o   = d1_q & ~d2_q;
    assign value_o   = value_q;
    assign channel_o = channel_q;

endmodule

// File: rtl/tvs_monitor.sv
// Per-channel TVS statistics: running average over 2**AVG_LOG2 samples plus
// min/max, written out as an avg/min/max burst, with hysteretic alarms.
module tvs_monitor
    import tvs_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int CH_W     = DEF_CH_W,
    parameter int AVG_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  resetn_i,
    input  logic                  valid_i,
    input  logic [DATA_W-1:0]     value_i,
    input  logic [CH_W-1:0]       channel_i,
    input  logic                  clr_i,
    input  logic [DATA_W-1:0]     thresh_hi_i,
    input  logic [DATA_W-1:0]     thresh_lo_i,
    output logic                  w_en_o,
    output logic [CH_W+1:0]       w_addr_o,
    output logic [DATA_W-1:0]     w_data_o,
    output logic [(1<<CH_W)-1:0]  alarm_o,
    output logic                  ovf_o
);

    localparam int NUM_CH = 1 << CH_W;
    localparam int SUM_W  = DATA_W + AVG_LOG2;
    localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    function automatic logic [DATA_W-1:0] calc_avg(input logic [SUM_W-1:0] s);
        logic [SUM_W-1:0] shifted;
        shifted = s >> AVG_LOG2;
        return shifted[DATA_W-1:0];
    endfunction

    logic              evt;
    logic [DATA_W-1:0] evt_val;
    logic [CH_W-1:0]   evt_ch;

    tvs_edge_capture #(
        .DATA_W (DATA_W),
        .CH_W   (CH_W)
    ) u_edge (
        .clk       (clk),
        .resetn_i  (resetn_i),
        .valid_i   (valid_i),
        .value_i   (value_i),
        .channel_i (channel_i),
        .event_o   (evt),
        .value_o   (evt_val),
        .channel_o (evt_ch)
    );

    state_e            state_q, state_d;
    logic              pend_vld_q, pend_vld_d;
    logic [DATA_W-1:0] pend_val_q, pend_val_d;
    logic [CH_W-1:0]   pend_ch_q, pend_ch_d;
    logic [DATA_W-1:0] cur_val_q, cur_val_d;
    logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
    logic [SUM_W-1:0]  sum_q [NUM_CH];
    logic [SUM_W-1:0]  sum_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [DATA_W-1:0] min_q [NUM_CH];
    logic [DATA_W-1:0] min_d [NUM_CH];
    logic [DATA_W-1:0] max_q [NUM_CH];
    logic [DATA_W-1:0] max_d [NUM_CH];
    logic [DATA_W-1:0] avg_q, avg_d;
    logic [NUM_CH-1:0] alarm_q, alarm_d;
    logic              ovf_q, ovf_d;
    logic [SUM_W-1:0]  acc_sum;
    sel_e              w_sel;

    always_comb begin
        state_d    = state_q;
        pend_vld_d = pend_vld_q;
        pend_val_d = pend_val_q;
        pend_ch_d  = pend_ch_q;
        cur_val_d  = cur_val_q;
        cur_ch_d   = cur_ch_q;
        sum_d      = sum_q;
        cnt_d      = cnt_q;
        min_d      = min_q;
        max_d      = max_q;
        avg_d      = avg_q;
        alarm_d    = alarm_q;
        ovf_d      = ovf_q;
        w_en_o     = 1'b0;
        w_sel      = SEL_AVG;
        w_data_o   = '0;
        acc_sum    = sum_q[cur_ch_q] + SUM_W'(cur_val_q);

        case (state_q)
            IDLE: begin
                // A buffered sample goes first; a fresh event then refills the buffer.
                if (pend_vld_q) begin
                    cur_val_d  = pend_val_q;
                    cur_ch_d   = pend_ch_q;
                    state_d    = ACCUM;
                    pend_vld_d = evt;
                    pend_val_d = evt_val;
                    pend_ch_d  = evt_ch;
                end else if (evt) begin
                    cur_val_d = evt_val;
                    cur_ch_d  = evt_ch;
                    state_d   = ACCUM;
                end
            end
            ACCUM: begin
                if (cur_val_q < min_q[cur_ch_q]) min_d[cur_ch_q] = cur_val_q;
                if (cur_val_q > max_q[cur_ch_q]) max_d[cur_ch_q] = cur_val_q;
                if (cnt_q[cur_ch_q] == CNT_LAST) begin
                    cnt_d[cur_ch_q] = '0;
                    sum_d[cur_ch_q] = '0;
                    avg_d           = calc_avg(acc_sum);
                    state_d         = WR_AVG;
                end else begin
                    cnt_d[cur_ch_q] = cnt_q[cur_ch_q] + CNT_W'(1);
                    sum_d[cur_ch_q] = acc_sum;
                    state_d         = IDLE;
                end
            end
            WR_AVG: begin
                w_en_o   = 1'b1;
                w_sel    = SEL_AVG;
                w_data_o = avg_q;
                if (avg_q > thresh_hi_i)      alarm_d[cur_ch_q] = 1'b1;
                else if (avg_q < thresh_lo_i) alarm_d[cur_ch_q] = 1'b0;
                state_d  = WR_MIN;
            end
            WR_MIN: begin
                w_en_o   = 1'b1;
                w_sel    = SEL_MIN;
                w_data_o = min_q[cur_ch_q];
                state_d  = WR_MAX;
            end
            WR_MAX: begin
                w_en_o   = 1'b1;
                w_sel    = SEL_MAX;
                w_data_o = max_q[cur_ch_q];
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && evt) begin
            if (pend_vld_q) begin
                ovf_d = 1'b1;
            end else begin
                pend_vld_d = 1'b1;
                pend_val_d = evt_val;
                pend_ch_d  = evt_ch;
            end
        end

        // Clear overrides everything, including an event landing in the same cycle.
        if (clr_i) begin
            state_d    = IDLE;
            pend_vld_d = 1'b0;
            alarm_d    = '0;
            ovf_d      = 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                sum_d[i] = '0;
                cnt_d[i] = '0;
                min_d[i] = '1;
                max_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q    <= IDLE;
            pend_vld_q <= 1'b0;
            pend_val_q <= '0;
            pend_ch_q  <= '0;
            cur_val_q  <= '0;
            cur_ch_q   <= '0;
            avg_q      <= '0;
            alarm_q    <= '0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                sum_q[i] <= '0;
                cnt_q[i] <= '0;
                min_q[i] <= '1;
                max_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            pend_vld_q <= pend_vld_d;
            pend_val_q <= pend_val_d;
            pend_ch_q  <= pend_ch_d;
            cur_val_q  <= cur_val_d;
            cur_ch_q   <= cur_ch_d;
            avg_q      <= avg_d;
            alarm_q    <= alarm_d;
            ovf_q      <= ovf_d;
            sum_q      <= sum_d;
            cnt_q      <= cnt_d;
            min_q      <= min_d;
            max_q      <= max_d;
        end
    end

    assign w_addr_o = w_en_o ? {w_sel, cur_ch_q} : '0;
    assign alarm_o  = alarm_q;
    assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_tvs_monitor.sv
// Self-checking bench for tvs_monitor: table-driven sample streams with a
// write scoreboard, plus hand-written sequences for the multi-cycle corners.
module tb_tvs_monitor;

    logic        clk = 1'b0;
    logic        resetn_i = 1'b0;
    logic        valid_i = 1'b0;
    logic [15:0] value_i = '0;
    logic [1:0]  channel_i = '0;
    logic        clr_i = 1'b0;
    logic [15:0] thresh_hi_i = 16'd1000;
    logic [15:0] thresh_lo_i = 16'd900;
    logic        w_en_o;
    logic [3:0]  w_addr_o;
    logic [15:0] w_data_o;
    logic [3:0]  alarm_o;
    logic        ovf_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        bit          clr;
        logic [1:0]  ch;
        logic [15:0] val;
        bit          wr;
        logic [15:0] avg;
        logic [15:0] mn;
        logic [15:0] mx;
        bit          chk_al;
        bit          al;
    } vec_t;
    vec_t tbl[$];

    tvs_monitor dut (
        .clk         (clk),
        .resetn_i    (resetn_i),
        .valid_i     (valid_i),
        .value_i     (value_i),
        .channel_i   (channel_i),
        .clr_i       (clr_i),
        .thresh_hi_i (thresh_hi_i),
        .thresh_lo_i (thresh_lo_i),
        .w_en_o      (w_en_o),
        .w_addr_o    (w_addr_o),
        .w_data_o    (w_data_o),
        .alarm_o     (alarm_o),
        .ovf_o       (ovf_o)
    );

    always #5 clk = ~clk;

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (resetn_i && w_en_o) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: addr=%h data=%0d, none expected", w_addr_o, w_data_o);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (w_addr_o !== e.addr || w_data_o !== e.data) begin
                    bad++;
                    $display("FAIL write: got addr=%h data=%0d, want addr=%h data=%0d",
                             w_addr_o, w_data_o, e.addr, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic push_burst(input logic [1:0] ch, input logic [15:0] a,
                              input logic [15:0] mn, input logic [15:0] mx);
        exp_q.push_back('{addr: {2'd0, ch}, data: a});
        exp_q.push_back('{addr: {2'd1, ch}, data: mn});
        exp_q.push_back('{addr: {2'd2, ch}, data: mx});
    endtask

    task automatic send(input logic [1:0] ch, input logic [15:0] val, input int hold);
        @(posedge clk); #1;
        valid_i = 1'b1; value_i = val; channel_i = ch;
        repeat (hold) @(posedge clk);
        #1 valid_i = 1'b0;
        repeat (8) @(posedge clk);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 clr_i = 1'b1;
        @(posedge clk); #1 clr_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic add(input bit clr, input logic [1:0] ch, input logic [15:0] val, input bit wr,
                       input logic [15:0] a, input logic [15:0] mn, input logic [15:0] mx,
                       input bit chk_al, input bit al);
        tbl.push_back('{clr: clr, ch: ch, val: val, wr: wr, avg: a, mn: mn, mx: mx,
                        chk_al: chk_al, al: al});
    endtask

    initial begin
        // Averaging of one channel, then two interleaved channels.
        add(0, 1, 100,  0, 0, 0, 0, 0, 0);
        add(0, 1, 200,  0, 0, 0, 0, 0, 0);
        add(0, 1, 300,  0, 0, 0, 0, 0, 0);
        add(0, 1, 401,  1, 250, 100, 401, 1, 0);
        add(0, 0, 10,   0, 0, 0, 0, 0, 0);
        add(0, 2, 1000, 0, 0, 0, 0, 0, 0);
        add(0, 0, 20,   0, 0, 0, 0, 0, 0);
        add(0, 2, 2000, 0, 0, 0, 0, 0, 0);
        add(0, 0, 30,   0, 0, 0, 0, 0, 0);
        add(0, 2, 3000, 0, 0, 0, 0, 0, 0);
        add(0, 0, 44,   1, 26, 10, 44, 1, 0);
        add(0, 2, 4003, 1, 2500, 1000, 4003, 1, 1);
        // Alarm hysteresis on ch0 after a clear.
        add(1, 0, 1001, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1001, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1001, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1001, 1, 1001, 1001, 1001, 1, 1);
        for (int i = 0; i < 3; i++) add(0, 0, 950, 0, 0, 0, 0, 0, 0);
        add(0, 0, 950,  1, 950, 950, 1001, 1, 1);
        for (int i = 0; i < 3; i++) add(0, 0, 899, 0, 0, 0, 0, 0, 0);
        add(0, 0, 899,  1, 899, 899, 1001, 1, 0);

        // Reset state.
        @(negedge clk);
        check("reset_outputs", {w_en_o, w_addr_o, w_data_o, alarm_o, ovf_o}, 0);
        @(posedge clk); #1 resetn_i = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].clr) begin
                pulse_clr();
                @(negedge clk);
                check("clr_alarm", alarm_o, 0);
            end
            if (tbl[i].wr) push_burst(tbl[i].ch, tbl[i].avg, tbl[i].mn, tbl[i].mx);
            send(tbl[i].ch, tbl[i].val, 1);
            if (tbl[i].chk_al) check($sformatf("alarm_row%0d", i), alarm_o[tbl[i].ch], tbl[i].al);
        end
        drain("table_drain");

        // Long valid pulse yields a single event; also checks first-write latency.
        pulse_clr();
        send(3, 7, 10);
        send(3, 7, 1);
        send(3, 7, 1);
        push_burst(3, 7, 7, 7);
        @(posedge clk); #1;
        valid_i = 1'b1; value_i = 16'd7; channel_i = 2'd3;
        @(posedge clk); #1 valid_i = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check("first_write_latency", {w_en_o, w_addr_o}, {1'b1, 4'h3});
        repeat (8) @(posedge clk);
        drain("hold_drain");

        // Two events during a write burst: first buffered, second dropped.
        pulse_clr();
        send(1, 40, 1);
        send(1, 40, 1);
        send(1, 40, 1);
        push_burst(1, 40, 40, 40);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            valid_i   = (k % 2 == 0);
            value_i   = (k == 0) ? 16'd40 : (k == 2) ? 16'd5 : 16'd6;
            channel_i = (k == 0) ? 2'd1 : 2'd2;
        end
        @(posedge clk); #1 valid_i = 1'b0;
        repeat (8) @(posedge clk);
        check("ovf_set", ovf_o, 1);
        send(2, 5, 1);
        send(2, 5, 1);
        push_burst(2, 5, 5, 5);
        send(2, 5, 1);
        drain("pending_drain");
        check("ovf_sticky", ovf_o, 1);
        pulse_clr();
        @(negedge clk);
        check("ovf_cleared", ovf_o, 0);

        // Reset mid-accumulation discards the partial sum and min/max.
        send(3, 50, 1);
        send(3, 60, 1);
        @(posedge clk); #1 resetn_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mid_reset_outputs", {w_en_o, w_addr_o, w_data_o, alarm_o, ovf_o}, 0);
        end
        @(posedge clk); #1 resetn_i = 1'b1;
        send(3, 8, 1);
        send(3, 8, 1);
        send(3, 8, 1);
        push_burst(3, 8, 8, 8);
        send(3, 8, 1);
        drain("post_reset_drain");

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
